// File: rtl/transpose_8x8_buffer.sv
// Ping-pong 8x8 transpose: row-major coefficients in, column-major coefficients out.
// Latency: first output registered 1 cycle after the edge capturing a block's 64th sample.
// Backpressure: none; input is accepted whenever En_In is high, output streams 64 cycles per block.
module transpose_8x8_buffer #(
    parameter int WIDTH = 8
) (
    input  logic                    Clock,
    input  logic                    Reset_n,
    input  logic signed [WIDTH+1:0] In_Data,
    input  logic                    En_In,
    output logic signed [WIDTH+1:0] Out_Data,
    output logic                    En_Out,
    output logic                    Block_Done
);

    localparam int DW = WIDTH + 2;

    // Two 64-entry banks, bank select is the address MSB.
    logic signed [DW-1:0] mem [0:127];

    logic [5:0] wr_cnt;
    logic [5:0] rd_cnt;
    logic       wr_bank;
    logic       rd_bank;
    logic [1:0] full;
    logic [1:0] full_nxt;
    logic [6:0] wr_addr;
    logic [6:0] rd_addr;
    logic       rd_go;
    logic       wr_last;
    logic       rd_last;

    // Writes are row-major; reads swap row/column fields of the counter.
    assign wr_addr = {wr_bank, wr_cnt};
    assign rd_addr = {rd_bank, rd_cnt[2:0], rd_cnt[5:3]};
    assign rd_go   = full[rd_bank];
    assign wr_last = En_In && (wr_cnt == 6'd63);
    assign rd_last = rd_go && (rd_cnt == 6'd63);

    // Sample storage; contents need no reset since the full flags gate every read.
    always_ff @(posedge Clock) begin
        if (En_In) begin
            mem[wr_addr] <= In_Data;
        end
    end

    // Write counter advances only on valid samples and flips bank on wrap.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_cnt  <= 6'd0;
            wr_bank <= 1'b0;
        end else if (En_In) begin
            wr_cnt <= wr_cnt + 6'd1;
            if (wr_cnt == 6'd63) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Full flags: set by the 64th write, cleared by the 64th read (banks always differ).
    always_comb begin
        full_nxt = full;
        if (rd_last) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (wr_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    // Full flag register.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            full <= 2'b00;
        end else begin
            full <= full_nxt;
        end
    end

    // Read side: stream a full bank gaplessly, then hop to the other bank if it is ready.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_cnt     <= 6'd0;
            rd_bank    <= 1'b0;
            Out_Data   <= '0;
            En_Out     <= 1'b0;
            Block_Done <= 1'b0;
        end else if (rd_go) begin
            Out_Data   <= mem[rd_addr];
            En_Out     <= 1'b1;
            Block_Done <= rd_last;
            rd_cnt     <= rd_cnt + 6'd1;
            if (rd_last) begin
                rd_bank <= ~rd_bank;
            end
        end else begin
            Out_Data   <= '0;
            En_Out     <= 1'b0;
            Block_Done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_transpose_8x8_buffer.sv
module tb_transpose_8x8_buffer;

    localparam int WIDTH = 8;
    localparam int DW    = WIDTH + 2;

    logic                 Clock;
    logic                 Reset_n;
    logic signed [DW-1:0] In_Data;
    logic                 En_In;
    logic signed [DW-1:0] Out_Data;
    logic                 En_Out;
    logic                 Block_Done;

    transpose_8x8_buffer #(.WIDTH(WIDTH)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .In_Data    (In_Data),
        .En_In      (En_In),
        .Out_Data   (Out_Data),
        .En_Out     (En_Out),
        .Block_Done (Block_Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    logic signed [DW-1:0] sb [$];
    logic signed [DW-1:0] blk [64];

    int out_idx   = 0;
    int run_len   = 0;
    int max_run   = 0;
    int n_done    = 0;
    int last_done = 0;
    int done_gap  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge Clock) cyc++;

    // Output monitor: pops the scoreboard on every valid output.
    always @(negedge Clock) begin
        if (!Reset_n) begin
            out_idx = 0;
            run_len = 0;
        end else if (En_Out) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                chk("data", int'(Out_Data), int'(sb.pop_front()));
            end
            chk("block_done", int'(Block_Done), (out_idx == 63) ? 1 : 0);
            out_idx = (out_idx + 1) % 64;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (Block_Done) begin
                done_gap  = cyc - last_done;
                last_done = cyc;
                n_done++;
            end
        end else begin
            chk("idle_data_zero", int'(Out_Data), 0);
            chk("idle_done_zero", int'(Block_Done), 0);
            run_len = 0;
        end
    end

    task automatic put(input logic signed [DW-1:0] v);
        @(posedge Clock);
        #1;
        En_In   = 1'b1;
        In_Data = v;
    endtask

    task automatic idle_cycle();
        @(posedge Clock);
        #1;
        En_In   = 1'b0;
        In_Data = DW'($urandom);
    endtask

    // Drives blk[] (optionally with a gap after each sample) and queues the transposed result.
    task automatic send_block(input bit gapped);
        for (int i = 0; i < 64; i++) begin
            put(blk[i]);
            if (gapped && i < 63) idle_cycle();
        end
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++)
                sb.push_back(blk[r*8 + c]);
    endtask

    // After send_block of an isolated block: output must start exactly one cycle after capture.
    task automatic check_first_latency(input string tag);
        idle_cycle();
        chk({tag, "_pre"}, int'(En_Out), 0);
        @(posedge Clock);
        #1;
        chk({tag, "_first"}, int'(En_Out), 1);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 400 && sb.size() != 0; k++) @(posedge Clock);
        chk({tag, "_drain"}, sb.size(), 0);
        repeat (3) @(posedge Clock);
        #1;
        chk({tag, "_idle_after"}, int'(En_Out), 0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge Clock);
        #2;
        Reset_n = 1'b0;
        En_In   = 1'b0;
        #1;
        chk({tag, "_en_out"}, int'(En_Out), 0);
        chk({tag, "_out_data"}, int'(Out_Data), 0);
        chk({tag, "_done"}, int'(Block_Done), 0);
        sb.delete();
        repeat (2) @(posedge Clock);
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic load_ramp(input int base);
        for (int i = 0; i < 64; i++) blk[i] = DW'(base + i);
    endtask

    initial begin
        Reset_n = 1'b1;
        En_In   = 1'b0;
        In_Data = '0;
        #2;
        Reset_n = 1'b0;
        #1;
        chk("rst_en_out", int'(En_Out), 0);
        chk("rst_out_data", int'(Out_Data), 0);
        chk("rst_done", int'(Block_Done), 0);
        repeat (3) @(posedge Clock);
        #1;
        Reset_n = 1'b1;

        // Single contiguous block.
        load_ramp(0);
        send_block(1'b0);
        check_first_latency("single");
        drain("single");

        // Back-to-back continuous blocks.
        max_run = 0;
        n_done  = 0;
        load_ramp(0);
        send_block(1'b0);
        load_ramp(100);
        send_block(1'b0);
        idle_cycle();
        drain("b2b");
        chk("b2b_run", max_run, 128);
        chk("b2b_done_count", n_done, 2);
        chk("b2b_done_gap", done_gap, 64);

        // Gapped input.
        load_ramp(0);
        send_block(1'b1);
        check_first_latency("gapped");
        drain("gapped");

        // Signed extremes.
        for (int i = 0; i < 64; i++) blk[i] = (i % 2 == 0) ? -10'sd512 : 10'sd511;
        send_block(1'b0);
        check_first_latency("extreme");
        drain("extreme");

        // Reset after 30 samples of a block.
        load_ramp(0);
        for (int i = 0; i < 30; i++) put(DW'(200 + i));
        do_reset("rst_midblk");
        send_block(1'b0);
        check_first_latency("after_rst_in");
        drain("after_rst_in");

        // Reset during readout.
        load_ramp(0);
        send_block(1'b0);
        idle_cycle();
        repeat (10) @(posedge Clock);
        do_reset("rst_readout");
        load_ramp(0);
        send_block(1'b0);
        check_first_latency("after_rst_out");
        drain("after_rst_out");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
